// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared access-size and FSM encodings plus byte-lane helpers for the data memory LSU.
package data_mem_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;
  typedef enum logic [1:0] {IDLE, SPLIT, RESP} lsu_state_e;
  // Bits [3:0] enable lanes of word N, bits [7:4] lanes of word N+1.
  function automatic logic [7:0] byte_mask(input mem_size_e size, input logic [1:0] lane);
    logic [7:0] base;
    base = size == MEM_BYTE ? 8'h01 : size == MEM_HALF ? 8'h03 : 8'h0f;
    return base << lane;
  endfunction
  function automatic logic [5:0] lane_shift(input logic [1:0] lane);
    return {lane, 3'b000};
  endfunction
endpackage

// File: rtl/data_mem_if.sv
// data_mem_if: request/response bus between the core memory stage and the data memory LSU.
interface data_mem_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/data_mem_ram.sv
// data_mem_ram: word RAM with byte-enable writes and one-cycle synchronous read.
module data_mem_ram #(
  parameter int    ADDR_WIDTH = 17,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-3:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**(ADDR_WIDTH-2)];
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte/half/word load-store unit over a windowed synchronous RAM.
// Define DATA_MEM_MISALIGN_SPLIT_EN to split misaligned in-range accesses into two word beats.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 17,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] START_ADDRESS = 32'h10000,
  parameter string       INIT_FILE     = ""
) (
  input  logic      clk,
  input  logic      rst_n,
  data_mem_if.slave bus
);
  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [32:0] LIMIT = 33'(1) << ADDR_WIDTH;
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  if (DATA_WIDTH != 32) begin : g_width_check
    $error("data_mem_lsu: DATA_WIDTH must be 32");
  end
  lsu_state_e state, state_n;
  mem_size_e size, r_size;
  logic [31:0] offset, ram_rdata, lo_word, shifted, ext, ram_wdata, r_wdata_hi;
  logic [32:0] last;
  logic [7:0] mask;
  logic [63:0] wide_wdata, wide_rdata;
  logic misaligned, out_of_range, err_now, accept, go_split;
  logic r_we, r_uns, r_err, r_split, ram_en, ram_we;
  logic [1:0] r_lane;
  logic [3:0] r_be_hi, ram_be;
  logic [WW-1:0] r_word, ram_addr;
  always_comb begin
    size = mem_size_e'(bus.req_size_i);
    offset = bus.req_addr_i - START_ADDRESS;
    last = {1'b0, offset} + (size == MEM_WORD ? 33'd3 : size == MEM_HALF ? 33'd1 : 33'd0);
    out_of_range = bus.req_addr_i < START_ADDRESS || last >= LIMIT;
    misaligned = size == MEM_HALF ? bus.req_addr_i[0] : size == MEM_WORD ? |bus.req_addr_i[1:0] : 1'b0;
    err_now = size == MEM_RSVD || out_of_range || (misaligned && !SPLIT_EN);
    go_split = misaligned && !err_now;
    accept = bus.req_valid_i && bus.req_ready_o;
    mask = byte_mask(size, bus.req_addr_i[1:0]);
    wide_wdata = {32'b0, bus.req_wdata_i} << lane_shift(bus.req_addr_i[1:0]);
    state_n = state == IDLE ? (accept ? (go_split ? SPLIT : RESP) : IDLE) :
              state == SPLIT ? RESP : (bus.rsp_ready_i ? IDLE : RESP);
    // The RAM port is driven by the new request in IDLE and by the second beat in SPLIT; it idles in RESP so read data holds.
    ram_en = state == SPLIT || (accept && !err_now);
    ram_we = state == SPLIT ? r_we : bus.req_we_i;
    ram_be = state == SPLIT ? r_be_hi : mask[3:0];
    ram_addr = state == SPLIT ? r_word + WW'(1) : offset[ADDR_WIDTH-1:2];
    ram_wdata = state == SPLIT ? r_wdata_hi : wide_wdata[31:0];
    wide_rdata = r_split ? {ram_rdata, lo_word} : {32'b0, ram_rdata};
    shifted = 32'(wide_rdata >> lane_shift(r_lane));
    ext = r_size == MEM_BYTE ? {{24{~r_uns & shifted[7]}}, shifted[7:0]} :
          r_size == MEM_HALF ? {{16{~r_uns & shifted[15]}}, shifted[15:0]} : shifted;
    bus.req_ready_o = rst_n && state == IDLE;
    bus.rsp_valid_o = state == RESP;
    bus.rsp_err_o = state == RESP && r_err;
    bus.rsp_rdata_o = (state == RESP && !r_err && !r_we) ? ext : 32'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_size <= MEM_BYTE;
      r_we <= 1'b0;
      r_uns <= 1'b0;
      r_err <= 1'b0;
      r_split <= 1'b0;
      r_lane <= 2'b0;
      r_word <= '0;
      r_be_hi <= 4'b0;
      r_wdata_hi <= 32'b0;
      lo_word <= 32'b0;
    end else begin
      if (accept) begin
        r_size <= size;
        r_we <= bus.req_we_i;
        r_uns <= bus.req_unsigned_i;
        r_err <= err_now;
        r_split <= go_split;
        r_lane <= bus.req_addr_i[1:0];
        r_word <= offset[ADDR_WIDTH-1:2];
        r_be_hi <= mask[7:4];
        r_wdata_hi <= wide_wdata[63:32];
      end
      if (state == SPLIT) lo_word <= ram_rdata;
    end
  data_mem_ram #(.ADDR_WIDTH(ADDR_WIDTH), .INIT_FILE(INIT_FILE)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed vectors for data_mem_lsu checked against a byte-addressed reference model.
module tb_data_mem_lsu;
  localparam int AW = 17;
  localparam longint START = 64'h10000;
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
  localparam bit split_en = 1'b1;
`else
  localparam bit split_en = 1'b0;
`endif
  typedef struct packed {logic err; logic [31:0] rdata;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];
  logic [7:0] mem_m [longint];
  logic [31:0] rd;
  logic er;
  data_mem_if bus();
  data_mem_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .START_ADDRESS(32'h10000), .INIT_FILE("")) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask
  function automatic void model(input bit we, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output exp_t e, output int lat);
    int n;
    longint off;
    bit mis;
    logic [31:0] v;
    n = 1 << size;
    off = longint'(addr) - START;
    mis = size != 2'd0 && (addr % n) != 0;
    e.err = size == 2'd3 || off < 0 || off + n > (longint'(1) << AW) || (mis && !split_en);
    lat = (mis && !e.err) ? 2 : 1;
    v = 0;
    if (!e.err)
      for (int i = 0; i < n; i++)
        if (we) mem_m[off + i] = wdata[8*i +: 8];
        else v[8*i +: 8] = mem_m[off + i];
    if (!e.err && !we && !uns && n < 4 && v[8*n-1]) v = v | (32'hffffffff << (8*n));
    e.rdata = (we || e.err) ? 32'h0 : v;
  endfunction
  task automatic access(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdata, output logic err);
    exp_t e;
    int lat, elat;
    model(we, size, uns, addr, wdata, e, elat);
    @(negedge clk);
    check("req_ready_idle", {31'b0, bus.req_ready_o}, 32'd1);
    bus.req_valid_i = 1'b1;
    bus.req_we_i = we;
    bus.req_size_i = size;
    bus.req_unsigned_i = uns;
    bus.req_addr_i = addr;
    bus.req_wdata_i = wdata;
    bus.rsp_ready_i = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid_o && lat < 8) begin
      lat++;
      @(negedge clk);
    end
    check("latency", lat, elat);
    rdata = bus.rsp_rdata_o;
    err = bus.rsp_err_o;
    repeat (hold) begin
      check("bp_req_ready", {31'b0, bus.req_ready_o}, 32'd0);
      check("bp_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'd1);
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready_i = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check("post_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
    check("post_req_ready", {31'b0, bus.req_ready_o}, 32'd1);
  endtask
  task automatic vec(input string name, input bit we, input logic [1:0] size, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     input logic [31:0] want_rd, input logic want_er);
    access(we, size, uns, addr, wdata, hold, rd, er);
    check({name, "_rdata"}, rd, want_rd);
    check({name, "_err"}, {31'b0, er}, {31'b0, want_er});
  endtask
  // Every cycle a response is presented it must match the model's prediction for the outstanding access.
  always @(negedge clk)
    if (rst_n && bus.rsp_valid_o) begin
      if (exp_q.size() == 0) check("spurious_rsp", {31'b0, bus.rsp_valid_o}, 32'd0);
      else begin
        check("rsp_err", {31'b0, bus.rsp_err_o}, {31'b0, exp_q[0].err});
        check("rsp_rdata", bus.rsp_rdata_o, exp_q[0].rdata);
      end
    end
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_we_i = 1'b0;
    bus.req_size_i = 2'b0;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i = 32'h0;
    bus.req_wdata_i = 32'h0;
    bus.rsp_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_req_ready", {31'b0, bus.req_ready_o}, 32'd0);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
    check("rst_rsp_err", {31'b0, bus.rsp_err_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_req_ready", {31'b0, bus.req_ready_o}, 32'd1);
    vec("st_w", 1, 2'd2, 0, 32'h10000, 32'hdeadbeef, 0, 32'h0, 0);
    vec("ld_w", 0, 2'd2, 0, 32'h10000, 32'h0, 0, 32'hdeadbeef, 0);
    vec("ld_b_s", 0, 2'd0, 0, 32'h10003, 32'h0, 0, 32'hffffffde, 0);
    vec("ld_b_u", 0, 2'd0, 1, 32'h10003, 32'h0, 0, 32'h000000de, 0);
    vec("ld_h_s", 0, 2'd1, 0, 32'h10002, 32'h0, 0, 32'hffffdead, 0);
    vec("ld_h_u", 0, 2'd1, 1, 32'h10000, 32'h0, 0, 32'h0000beef, 0);
    vec("st_b", 1, 2'd0, 0, 32'h10001, 32'hffffffa5, 0, 32'h0, 0);
    vec("st_h", 1, 2'd1, 0, 32'h10002, 32'hffff1234, 0, 32'h0, 0);
    vec("ld_w2", 0, 2'd2, 0, 32'h10000, 32'h0, 0, 32'h1234a5ef, 0);
    vec("st_w4", 1, 2'd2, 0, 32'h10004, 32'haabbccdd, 0, 32'h0, 0);
    vec("st_w8", 1, 2'd2, 0, 32'h10008, 32'heeff0011, 0, 32'h0, 0);
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    vec("st_mis", 1, 2'd2, 0, 32'h10006, 32'h11223344, 0, 32'h0, 0);
    vec("ld_mis", 0, 2'd2, 0, 32'h10006, 32'h0, 0, 32'h11223344, 0);
    vec("ld_w4", 0, 2'd2, 0, 32'h10004, 32'h0, 0, 32'h3344ccdd, 0);
    vec("ld_w8", 0, 2'd2, 0, 32'h10008, 32'h0, 0, 32'heeff1122, 0);
    vec("ld_mis_h", 0, 2'd1, 0, 32'h10007, 32'h0, 0, 32'h00002233, 0);
`else
    vec("st_mis", 1, 2'd2, 0, 32'h10006, 32'h11223344, 0, 32'h0, 1);
    vec("ld_mis", 0, 2'd2, 0, 32'h10006, 32'h0, 0, 32'h0, 1);
    vec("ld_w4", 0, 2'd2, 0, 32'h10004, 32'h0, 0, 32'haabbccdd, 0);
    vec("ld_w8", 0, 2'd2, 0, 32'h10008, 32'h0, 0, 32'heeff0011, 0);
    vec("ld_mis_h", 0, 2'd1, 0, 32'h10007, 32'h0, 0, 32'h0, 1);
`endif
    vec("ld_below", 0, 2'd2, 0, 32'h0fffc, 32'h0, 0, 32'h0, 1);
    vec("st_top", 1, 2'd2, 0, 32'h2fffc, 32'hcafef00d, 0, 32'h0, 0);
    vec("st_cross", 1, 2'd2, 0, 32'h2fffe, 32'h55555555, 0, 32'h0, 1);
    vec("ld_top", 0, 2'd2, 0, 32'h2fffc, 32'h0, 0, 32'hcafef00d, 0);
    vec("ld_last_b", 0, 2'd0, 0, 32'h2ffff, 32'h0, 0, 32'hffffffca, 0);
    vec("ld_past", 0, 2'd0, 0, 32'h30000, 32'h0, 0, 32'h0, 1);
    vec("ld_rsvd", 0, 2'd3, 0, 32'h10000, 32'h0, 0, 32'h0, 1);
    vec("st_rsvd", 1, 2'd3, 0, 32'h10000, 32'h0, 0, 32'h0, 1);
    vec("ld_after_rsvd", 0, 2'd2, 0, 32'h10000, 32'h0, 0, 32'h1234a5ef, 0);
    vec("bp", 0, 2'd2, 0, 32'h10000, 32'h0, 5, 32'h1234a5ef, 0);
    vec("bp_next", 0, 2'd0, 1, 32'h10001, 32'h0, 0, 32'h000000a5, 0);
    vec("st_wc", 1, 2'd2, 0, 32'h1000c, 32'h01020304, 0, 32'h0, 0);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i = 1'b1;
    bus.req_size_i = 2'd2;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i = 32'h1000a;
    bus.req_wdata_i = 32'h99887766;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    check("pre_rst_valid", {31'b0, bus.rsp_valid_o}, split_en ? 32'd0 : 32'd1);
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    mem_m[32'h1000a - START] = 8'h66;
    mem_m[32'h1000b - START] = 8'h77;
`endif
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
    check("mid_rst_ready", {31'b0, bus.req_ready_o}, 32'd0);
    check("mid_rst_err", {31'b0, bus.rsp_err_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_ready", {31'b0, bus.req_ready_o}, 32'd1);
    vec("rst_w8", 0, 2'd2, 0, 32'h10008, 32'h0, 0, split_en ? 32'h77661122 : 32'heeff0011, 0);
    vec("rst_wc", 0, 2'd2, 0, 32'h1000c, 32'h0, 0, 32'h01020304, 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
